sccb_config_seq: RTL and testbench

- Parametrised successor to the camera register-configuration sequencer.
- Walks a register/value table in a ROM and issues each entry as a write transaction to the SCCB/I2C master.
- Beyond the previous block it adds:
  - configurable register/value widths (8- or 16-bit sensor addressing);
  - per-entry programmable delays;
  - optional read-back verify with bounded retries;
  - explicit error reporting.
- Sits between the sensor register ROM and the SCCB master; drives config-done and error LEDs.

---
 rtl/sccb_cfg_pkg.sv | 42 ++++
 rtl/sccb_config_seq_if.sv | 20 ++
 rtl/sccb_ms_timer.sv | 33 +++
 rtl/sccb_config_seq.sv | 180 ++++++++++++++++++
 tb/tb_sccb_config_seq.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sccb_cfg_pkg.sv
// Shared definitions for the SCCB configuration sequencer: FSM encoding,
// entry decoding helpers and the ms-to-cycles conversion.
package sccb_cfg_pkg;

  typedef enum logic [1:0] {
    ENT_WRITE,
    ENT_DELAY,
    ENT_END
  } entry_kind_t;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_FETCH   = 4'd1;
  localparam logic [3:0] ST_WR_REQ  = 4'd2;
  localparam logic [3:0] ST_WR_WAIT = 4'd3;
  localparam logic [3:0] ST_RD_REQ  = 4'd4;
  localparam logic [3:0] ST_RD_WAIT = 4'd5;
  localparam logic [3:0] ST_RETRY   = 4'd6;
  localparam logic [3:0] ST_DELAY   = 4'd7;
  localparam logic [3:0] ST_NEXT    = 4'd8;
  localparam logic [3:0] ST_DONE    = 4'd9;
  localparam logic [3:0] ST_ERROR   = 4'd10;

  // All-ones marker of a given field width, zero-extended to 32 bits.
  function automatic logic [31:0] marker_ones(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic entry_kind_t decode_entry(input logic [31:0] reg_f,
                                               input logic [31:0] val_f,
                                               input int unsigned reg_w,
                                               input int unsigned val_w);
    if (reg_f != marker_ones(reg_w)) return ENT_WRITE;
    if (val_f == marker_ones(val_w)) return ENT_END;
    return ENT_DELAY;
  endfunction

  function automatic int unsigned ms_to_cycles(input int unsigned ms,
                                               input int unsigned clk_freq);
    return ms * (clk_freq / 1000);
  endfunction

endpackage

// File: rtl/sccb_config_seq_if.sv
// Request/completion bus between the configuration sequencer (master)
// and the SCCB/I2C transaction engine (slave).
interface sccb_config_seq_if #(
  parameter int unsigned REG_W = 8,
  parameter int unsigned VAL_W = 8
);
  logic             valid;
  logic             ready;
  logic             rd;
  logic [REG_W-1:0] reg_addr;
  logic [VAL_W-1:0] wdata;
  logic             done;
  logic             nack;
  logic [VAL_W-1:0] rdata;

  modport master (output valid, rd, reg_addr, wdata,
                  input  ready, done, nack, rdata);
  modport slave  (input  valid, rd, reg_addr, wdata,
                  output ready, done, nack, rdata);
endinterface

// File: rtl/sccb_ms_timer.sv
// Loadable millisecond down-counter; zero_o is high once the loaded
// interval has fully elapsed.
module sccb_ms_timer #(
  parameter int unsigned CLK_FREQ = 25_000_000,
  parameter int unsigned MAX_MS   = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] ms_i,
  output logic       zero_o
);
  import sccb_cfg_pkg::*;

  localparam int unsigned CYC_PER_MS = CLK_FREQ / 1000;
  localparam int unsigned CW         = $clog2(ms_to_cycles(MAX_MS, CLK_FREQ) + 1);

  logic [CW-1:0] count_reg;

  // Loaded with N-1 so that exactly N cycles are spent counting down.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_reg <= '0;
    end else if (load_i) begin
      count_reg <= CW'(ms_i * CYC_PER_MS) - CW'(1);
    end else if (count_reg != '0) begin
      count_reg <= count_reg - CW'(1);
    end
  end

  assign zero_o = (count_reg == '0);

endmodule

// File: rtl/sccb_config_seq.sv
// Walks a register/value ROM table and issues each entry as an SCCB write,
// with per-entry delays, optional read-back verify and bounded retries.
module sccb_config_seq #(
  parameter int unsigned CLK_FREQ  = 25_000_000,
  parameter int unsigned REG_W     = 8,
  parameter int unsigned VAL_W     = 8,
  parameter int unsigned ROM_AW    = 8,
  parameter int unsigned DELAY_MS  = 10,
  parameter int unsigned VERIFY    = 0,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic [ROM_AW-1:0] rom_addr_o,
  input  logic [REG_W-1:0]  rom_reg_i,
  input  logic [VAL_W-1:0]  rom_val_i,
  sccb_config_seq_if.master txn,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ROM_AW-1:0] err_idx_o
);
  import sccb_cfg_pkg::*;

  localparam int unsigned   RW        = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  logic [3:0]        state_reg, state_next;
  logic [ROM_AW-1:0] addr_reg, addr_next;
  logic              fetch_wait_reg, fetch_wait_next;
  logic [REG_W-1:0]  reg_lat_reg, reg_lat_next;
  logic [VAL_W-1:0]  val_lat_reg, val_lat_next;
  logic [RW-1:0]     retry_reg, retry_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
  logic [ROM_AW-1:0] err_idx_reg, err_idx_next;
  entry_kind_t       kind;
  logic              timer_load;
  logic              timer_zero;
  logic [7:0]        delay_ms;

  assign delay_ms = (rom_val_i[7:0] == 8'd0) ? 8'(DELAY_MS) : rom_val_i[7:0];

  sccb_ms_timer #(
    .CLK_FREQ(CLK_FREQ),
    .MAX_MS  (255)
  ) u_timer (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .load_i(timer_load),
    .ms_i  (delay_ms),
    .zero_o(timer_zero)
  );

  always_comb begin
    state_next      = state_reg;
    addr_next       = addr_reg;
    fetch_wait_next = 1'b0;
    reg_lat_next    = reg_lat_reg;
    val_lat_next    = val_lat_reg;
    retry_next      = retry_reg;
    busy_next       = busy_reg;
    done_next       = done_reg;
    err_next        = err_reg;
    err_idx_next    = err_idx_reg;
    timer_load      = 1'b0;
    kind            = decode_entry(32'(rom_reg_i), 32'(rom_val_i), REG_W, VAL_W);

    case (state_reg)
      ST_IDLE: if (start_i) begin
        addr_next       = '0;
        done_next       = 1'b0;
        err_next        = 1'b0;
        err_idx_next    = '0;
        busy_next       = 1'b1;
        fetch_wait_next = 1'b1;
        state_next      = ST_FETCH;
      end
      // First FETCH cycle covers the ROM's registered read.
      ST_FETCH: if (!fetch_wait_reg) begin
        case (kind)
          ENT_END:   state_next = ST_DONE;
          ENT_DELAY: begin
            timer_load = 1'b1;
            state_next = ST_DELAY;
          end
          default: begin
            reg_lat_next = rom_reg_i;
            val_lat_next = rom_val_i;
            retry_next   = '0;
            state_next   = ST_WR_REQ;
          end
        endcase
      end
      ST_WR_REQ:  if (txn.ready) state_next = ST_WR_WAIT;
      ST_WR_WAIT: if (txn.done) begin
        if (txn.nack)         state_next = ST_RETRY;
        else if (VERIFY != 0) state_next = ST_RD_REQ;
        else                  state_next = ST_NEXT;
      end
      ST_RD_REQ:  if (txn.ready) state_next = ST_RD_WAIT;
      ST_RD_WAIT: if (txn.done) begin
        if (txn.nack || (txn.rdata != val_lat_reg)) state_next = ST_RETRY;
        else                                        state_next = ST_NEXT;
      end
      ST_RETRY: begin
        if (retry_reg < RETRY_MAX) begin
          retry_next = retry_reg + RW'(1);
          state_next = ST_WR_REQ;
        end else begin
          err_next     = 1'b1;
          err_idx_next = addr_reg;
          state_next   = ST_ERROR;
        end
      end
      ST_DELAY: if (timer_zero) state_next = ST_NEXT;
      // The last table slot finishes the run even without an End entry.
      ST_NEXT: begin
        if (&addr_reg) begin
          state_next = ST_DONE;
        end else begin
          addr_next       = addr_reg + ROM_AW'(1);
          fetch_wait_next = 1'b1;
          state_next      = ST_FETCH;
        end
      end
      ST_DONE: begin
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end
      ST_ERROR: begin
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg      <= ST_IDLE;
      addr_reg       <= '0;
      fetch_wait_reg <= 1'b0;
      reg_lat_reg    <= '0;
      val_lat_reg    <= '0;
      retry_reg      <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
      err_idx_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      fetch_wait_reg <= fetch_wait_next;
      reg_lat_reg    <= reg_lat_next;
      val_lat_reg    <= val_lat_next;
      retry_reg      <= retry_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      err_reg        <= err_next;
      err_idx_reg    <= err_idx_next;
    end
  end

  // Request is decoded from state so it drops the instant reset asserts.
  assign txn.valid    = (state_reg == ST_WR_REQ) || (state_reg == ST_RD_REQ);
  assign txn.rd       = (state_reg == ST_RD_REQ);
  assign txn.reg_addr = reg_lat_reg;
  assign txn.wdata    = val_lat_reg;

  assign rom_addr_o = addr_reg;
  assign busy_o     = busy_reg;
  assign done_o     = done_reg;
  assign err_o      = err_reg;
  assign err_idx_o  = err_idx_reg;

endmodule

// File: tb/tb_sccb_config_seq.sv
// Directed bench for sccb_config_seq: an 8-bit write-only instance and a
// 16-bit verifying instance, each with a registered ROM and a master model.
module tb_sccb_config_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit          rd;
    logic [15:0] ra;
    logic [7:0]  d;
    int          cyc;
  } txn_t;

  // ---------------- instance A: 8-bit regs, write only ----------------
  sccb_config_seq_if #(.REG_W(8), .VAL_W(8)) ifa ();
  logic [3:0] addr_a, err_idx_a;
  logic [7:0] reg_a_q, val_a_q;
  logic       busy_a, done_a, err_a;
  logic [7:0] rom_a_reg [16];
  logic [7:0] rom_a_val [16];
  always @(posedge clk) begin
    reg_a_q <= rom_a_reg[addr_a];
    val_a_q <= rom_a_val[addr_a];
  end

  sccb_config_seq #(
    .CLK_FREQ(1_000_000), .REG_W(8), .VAL_W(8), .ROM_AW(4),
    .DELAY_MS(10), .VERIFY(0), .MAX_RETRY(2)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .rom_addr_o(addr_a),
    .rom_reg_i(reg_a_q), .rom_val_i(val_a_q), .txn(ifa),
    .busy_o(busy_a), .done_o(done_a), .err_o(err_a), .err_idx_o(err_idx_a)
  );

  txn_t       a_log[$];
  int         a_done_q[$];
  int         a_cnt = 0;
  bit         a_rand = 1'b0, a_hold = 1'b0, a_nack_en = 1'b0;
  logic [7:0] a_hold_reg = 8'h40, a_nack_reg = 8'h33, a_cur = 8'h00;

  always @(negedge clk) begin
    ifa.done  = 1'b0;
    ifa.nack  = 1'b0;
    ifa.rdata = 8'h00;
    if (rst) a_cnt = 0;
    else if (a_cnt > 0) begin
      a_cnt--;
      if (a_cnt == 0) begin
        ifa.done = 1'b1;
        ifa.nack = a_nack_en && (a_cur == a_nack_reg);
        a_done_q.push_back(cyc);
      end
    end
    ifa.ready = !(a_hold && ifa.reg_addr == a_hold_reg) &&
                (!a_rand || ($urandom_range(0, 1) == 1));
    if (!rst && ifa.valid && ifa.ready) begin
      a_log.push_back('{ifa.rd, 16'(ifa.reg_addr), ifa.wdata, cyc});
      $display("A txn %s reg=%02h data=%02h cyc=%0d", ifa.rd ? "RD" : "WR", ifa.reg_addr, ifa.wdata, cyc);
      a_cur = ifa.reg_addr;
      a_cnt = 2;
    end
  end

  // ---------------- instance B: 16-bit regs, verify ----------------
  sccb_config_seq_if #(.REG_W(16), .VAL_W(8)) ifb ();
  logic [1:0]  addr_b, err_idx_b;
  logic [15:0] reg_b_q;
  logic [7:0]  val_b_q;
  logic        busy_b, done_b, err_b;
  logic [15:0] rom_b_reg [4];
  logic [7:0]  rom_b_val [4];
  always @(posedge clk) begin
    reg_b_q <= rom_b_reg[addr_b];
    val_b_q <= rom_b_val[addr_b];
  end

  sccb_config_seq #(
    .CLK_FREQ(1_000_000), .REG_W(16), .VAL_W(8), .ROM_AW(2),
    .DELAY_MS(10), .VERIFY(1), .MAX_RETRY(2)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .rom_addr_o(addr_b),
    .rom_reg_i(reg_b_q), .rom_val_i(val_b_q), .txn(ifb),
    .busy_o(busy_b), .done_o(done_b), .err_o(err_b), .err_idx_o(err_idx_b)
  );

  txn_t       b_log[$];
  int         b_cnt = 0;
  int         b_bad = 0;
  bit         b_cur_rd = 1'b0;
  logic [7:0] b_mem = 8'h00;

  always @(negedge clk) begin
    ifb.done  = 1'b0;
    ifb.nack  = 1'b0;
    ifb.rdata = 8'h00;
    if (rst) b_cnt = 0;
    else if (b_cnt > 0) begin
      b_cnt--;
      if (b_cnt == 0) begin
        ifb.done = 1'b1;
        if (b_cur_rd) begin
          ifb.rdata = (b_bad > 0) ? 8'h7F : b_mem;
          if (b_bad > 0) b_bad--;
        end
      end
    end
    ifb.ready = ($urandom_range(0, 1) == 1);
    if (!rst && ifb.valid && ifb.ready) begin
      b_log.push_back('{ifb.rd, ifb.reg_addr, ifb.wdata, cyc});
      $display("B txn %s reg=%04h data=%02h cyc=%0d", ifb.rd ? "RD" : "WR", ifb.reg_addr, ifb.wdata, cyc);
      b_cur_rd = ifb.rd;
      if (!ifb.rd) b_mem = ifb.wdata;
      b_cnt = 3;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr_a();
    for (int i = 0; i < 16; i++) begin rom_a_reg[i] = 8'hFF; rom_a_val[i] = 8'hFF; end
  endtask

  task automatic clr_b();
    for (int i = 0; i < 4; i++) begin rom_b_reg[i] = 16'hFFFF; rom_b_val[i] = 8'hFF; end
  endtask

  task automatic go(input bit b);
    @(negedge clk);
    a_log.delete(); a_done_q.delete(); b_log.delete();
    if (b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_end(input bit b, input int maxc, input string tag);
    int n = 0;
    while (n < maxc && !(b ? (done_b || err_b) : (done_a || err_a))) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 32'(n < maxc), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  int n_33, n_rd;

  initial begin
    clr_a();
    clr_b();
    repeat (3) @(negedge clk);
    check("rst_addr_a", 32'(addr_a), 32'd0);
    check("rst_valid_a", 32'(ifa.valid), 32'd0);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_done_a", 32'(done_a), 32'd0);
    check("rst_err_a", 32'(err_a), 32'd0);
    check("rst_erridx_a", 32'(err_idx_a), 32'd0);
    check("rst_valid_b", 32'(ifb.valid), 32'd0);
    rst = 1'b0;

    // Two plain writes then End, with a stalling master.
    rom_a_reg[0] = 8'h12; rom_a_val[0] = 8'h80;
    rom_a_reg[1] = 8'h11; rom_a_val[1] = 8'h01;
    a_rand = 1'b1;
    go(1'b0);
    wait_end(1'b0, 300, "t1");
    check("t1_nwr", 32'(a_log.size()), 32'd2);
    if (a_log.size() >= 2) begin
      check("t1_reg0", 32'(a_log[0].ra), 32'h12);
      check("t1_dat0", 32'(a_log[0].d), 32'h80);
      check("t1_reg1", 32'(a_log[1].ra), 32'h11);
      check("t1_dat1", 32'(a_log[1].d), 32'h01);
      check("t1_rd1", 32'(a_log[1].rd), 32'd0);
    end
    check("t1_done", 32'(done_a), 32'd1);
    check("t1_busy", 32'(busy_a), 32'd0);
    check("t1_err", 32'(err_a), 32'd0);

    // Delay entries: 5 ms and default 10 ms at 1 MHz; gap = N + 7 cycles
    // from the completing done to the next accepted request.
    clr_a();
    rom_a_reg[0] = 8'h20; rom_a_val[0] = 8'h01;
    rom_a_reg[1] = 8'hFF; rom_a_val[1] = 8'h05;
    rom_a_reg[2] = 8'h21; rom_a_val[2] = 8'h02;
    rom_a_reg[3] = 8'hFF; rom_a_val[3] = 8'h00;
    rom_a_reg[4] = 8'h22; rom_a_val[4] = 8'h03;
    a_rand = 1'b0;
    go(1'b0);
    repeat (100) @(negedge clk);
    check("t2_busy_mid", 32'(busy_a), 32'd1);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_end(1'b0, 20000, "t2");
    check("t2_nwr", 32'(a_log.size()), 32'd3);
    if (a_log.size() >= 3 && a_done_q.size() >= 2) begin
      check("t2_reg0", 32'(a_log[0].ra), 32'h20);
      check("t2_gap5ms", 32'(a_log[1].cyc - a_done_q[0]), 32'd5007);
      check("t2_reg1", 32'(a_log[1].ra), 32'h21);
      check("t2_gap10ms", 32'(a_log[2].cyc - a_done_q[1]), 32'd10007);
      check("t2_reg2", 32'(a_log[2].ra), 32'h22);
    end
    check("t2_done", 32'(done_a), 32'd1);

    // Persistent NACK on entry 3: 1 + MAX_RETRY writes, then error.
    clr_a();
    rom_a_reg[0] = 8'h01; rom_a_val[0] = 8'h11;
    rom_a_reg[1] = 8'h02; rom_a_val[1] = 8'h22;
    rom_a_reg[2] = 8'h03; rom_a_val[2] = 8'h33;
    rom_a_reg[3] = 8'h33; rom_a_val[3] = 8'h44;
    a_rand = 1'b1;
    a_nack_en = 1'b1;
    go(1'b0);
    wait_end(1'b0, 500, "t4");
    repeat (5) @(negedge clk);
    n_33 = 0;
    foreach (a_log[i]) if (a_log[i].ra == 16'h0033) n_33++;
    check("t4_nwr33", 32'(n_33), 32'd3);
    check("t4_nwr", 32'(a_log.size()), 32'd6);
    check("t4_err", 32'(err_a), 32'd1);
    check("t4_erridx", 32'(err_idx_a), 32'd3);
    check("t4_done", 32'(done_a), 32'd0);
    check("t4_busy", 32'(busy_a), 32'd0);
    a_nack_en = 1'b0;

    // Reset while a request is held off at entry 1.
    clr_a();
    rom_a_reg[0] = 8'h41; rom_a_val[0] = 8'h01;
    rom_a_reg[1] = 8'h40; rom_a_val[1] = 8'h02;
    a_rand = 1'b0;
    a_hold = 1'b1;
    go(1'b0);
    repeat (20) @(negedge clk);
    check("t6_pre_valid", 32'(ifa.valid), 32'd1);
    check("t6_pre_addr", 32'(addr_a), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_wr_valid", 32'(ifa.valid), 32'd0);
    check("t6_wr_busy", 32'(busy_a), 32'd0);
    check("t6_wr_addr", 32'(addr_a), 32'd0);
    check("t6_wr_reg", 32'(ifa.reg_addr), 32'd0);
    check("t6_wr_wdata", 32'(ifa.wdata), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    a_hold = 1'b0;
    go(1'b0);
    wait_end(1'b0, 300, "t6_rerun");
    check("t6_rerun_n", 32'(a_log.size()), 32'd2);
    if (a_log.size() >= 1) check("t6_rerun_reg0", 32'(a_log[0].ra), 32'h41);
    check("t6_rerun_done", 32'(done_a), 32'd1);

    // Reset in the middle of a delay at entry 1.
    clr_a();
    rom_a_reg[0] = 8'h43; rom_a_val[0] = 8'h01;
    rom_a_reg[1] = 8'hFF; rom_a_val[1] = 8'h05;
    rom_a_reg[2] = 8'h42; rom_a_val[2] = 8'h01;
    go(1'b0);
    repeat (100) @(negedge clk);
    check("t6_dly_pre_busy", 32'(busy_a), 32'd1);
    check("t6_dly_pre_addr", 32'(addr_a), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_dly_busy", 32'(busy_a), 32'd0);
    check("t6_dly_addr", 32'(addr_a), 32'd0);
    check("t6_dly_done", 32'(done_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    go(1'b0);
    wait_end(1'b0, 6000, "t6_dly_rerun");
    check("t6_dly_rerun_n", 32'(a_log.size()), 32'd2);
    if (a_log.size() >= 2) begin
      check("t6_dly_reg0", 32'(a_log[0].ra), 32'h43);
      check("t6_dly_reg1", 32'(a_log[1].ra), 32'h42);
    end

    // Verify: two bad read-backs then a good one -> 3 write/read pairs.
    clr_b();
    rom_b_reg[0] = 16'h1234; rom_b_val[0] = 8'h80;
    b_bad = 2;
    go(1'b1);
    wait_end(1'b1, 1000, "t3");
    check("t3_ntxn", 32'(b_log.size()), 32'd6);
    n_rd = 0;
    foreach (b_log[i]) if (b_log[i].rd) n_rd++;
    check("t3_nrd", 32'(n_rd), 32'd3);
    if (b_log.size() >= 6) begin
      check("t3_wr_first", 32'(b_log[0].rd), 32'd0);
      check("t3_wr_last_data", 32'(b_log[4].d), 32'h80);
    end
    check("t3_done", 32'(done_b), 32'd1);
    check("t3_err", 32'(err_b), 32'd0);

    // 16-bit addressing; 00FF/FF is a write, only FFFF/FF ends.
    clr_b();
    rom_b_reg[0] = 16'h300A; rom_b_val[0] = 8'h76;
    rom_b_reg[1] = 16'h00FF; rom_b_val[1] = 8'hFF;
    go(1'b1);
    wait_end(1'b1, 1000, "t5");
    check("t5_ntxn", 32'(b_log.size()), 32'd4);
    if (b_log.size() >= 4) begin
      check("t5_reg0", 32'(b_log[0].ra), 32'h300A);
      check("t5_dat0", 32'(b_log[0].d), 32'h76);
      check("t5_reg2", 32'(b_log[2].ra), 32'h00FF);
    end
    check("t5_done", 32'(done_b), 32'd1);

    // No End entry: the run stops after the last table slot.
    for (int i = 0; i < 4; i++) begin
      rom_b_reg[i] = 16'(i + 1);
      rom_b_val[i] = 8'(8'h11 * (i + 1));
    end
    go(1'b1);
    wait_end(1'b1, 2000, "tnw");
    repeat (10) @(negedge clk);
    check("tnw_ntxn", 32'(b_log.size()), 32'd8);
    if (b_log.size() >= 8) begin
      check("tnw_reg_last", 32'(b_log[6].ra), 32'h0004);
      check("tnw_dat_last", 32'(b_log[6].d), 32'h44);
    end
    check("tnw_done", 32'(done_b), 32'd1);
    check("tnw_busy", 32'(busy_b), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
